// File: rtl/id_ex.sv
// rtl/id_ex.sv - ID/EX pipeline register with stall hold and optional flush bubble (ID_EX_FLUSH_EN)
module id_ex #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic [1:0]        ctlwb_out,
   input  logic [2:0]        ctlm_out,
   input  logic [3:0]        ctlex_out,
   input  logic [DATA_W-1:0] npc,
   input  logic [DATA_W-1:0] readdat1,
   input  logic [DATA_W-1:0] readdat2,
   input  logic [DATA_W-1:0] signext_out,
   input  logic [REG_W-1:0]  instr_2016,
   input  logic [REG_W-1:0]  instr_1511,
   output logic [1:0]        wb_ctlout,
   output logic [2:0]        m_ctlout,
   output logic [3:0]        ex_ctlout,
   output logic [DATA_W-1:0] npcout,
   output logic [DATA_W-1:0] rdata1out,
   output logic [DATA_W-1:0] rdata2out,
   output logic [DATA_W-1:0] s_extendout,
   output logic [REG_W-1:0]  instrout_2016,
   output logic [REG_W-1:0]  instrout_1511
);

   logic do_flush;

`ifdef ID_EX_FLUSH_EN
   assign do_flush = flush;
`else
   logic unused_flush;
   assign unused_flush = flush;
   assign do_flush     = 1'b0;
`endif

   // A flush overrides stall: the bubble carries fresh data but no control, so it has no effect downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ctlout     <= '0;
         m_ctlout      <= '0;
         ex_ctlout     <= '0;
         npcout        <= '0;
         rdata1out     <= '0;
         rdata2out     <= '0;
         s_extendout   <= '0;
         instrout_2016 <= '0;
         instrout_1511 <= '0;
      end else if (do_flush) begin
         wb_ctlout     <= '0;
         m_ctlout      <= '0;
         ex_ctlout     <= '0;
         npcout        <= npc;
         rdata1out     <= readdat1;
         rdata2out     <= readdat2;
         s_extendout   <= signext_out;
         instrout_2016 <= instr_2016;
         instrout_1511 <= instr_1511;
      end else if (!stall) begin
         wb_ctlout     <= ctlwb_out;
         m_ctlout      <= ctlm_out;
         ex_ctlout     <= ctlex_out;
         npcout        <= npc;
         rdata1out     <= readdat1;
         rdata2out     <= readdat2;
         s_extendout   <= signext_out;
         instrout_2016 <= instr_2016;
         instrout_1511 <= instr_1511;
      end
   end

endmodule

// File: tb/tb_id_ex.sv
// tb/tb_id_ex.sv - directed self-checking bench for id_ex
module tb_id_ex;

   logic        clk;
   logic        rst_n = 1'b1;
   logic        stall, flush;
   logic [1:0]  ctlwb_out;
   logic [2:0]  ctlm_out;
   logic [3:0]  ctlex_out;
   logic [31:0] npc, readdat1, readdat2, signext_out;
   logic [4:0]  instr_2016, instr_1511;
   logic [1:0]  wb_ctlout;
   logic [2:0]  m_ctlout;
   logic [3:0]  ex_ctlout;
   logic [31:0] npcout, rdata1out, rdata2out, s_extendout;
   logic [4:0]  instrout_2016, instrout_1511;

   int total = 0;
   int bad   = 0;

   logic [146:0] vec_a, vec_b, zero_vec, got;

   id_ex dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out), .ctlex_out(ctlex_out),
      .npc(npc), .readdat1(readdat1), .readdat2(readdat2), .signext_out(signext_out),
      .instr_2016(instr_2016), .instr_1511(instr_1511),
      .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .ex_ctlout(ex_ctlout),
      .npcout(npcout), .rdata1out(rdata1out), .rdata2out(rdata2out),
      .s_extendout(s_extendout), .instrout_2016(instrout_2016), .instrout_1511(instrout_1511)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign got = {wb_ctlout, m_ctlout, ex_ctlout, npcout, rdata1out, rdata2out,
                 s_extendout, instrout_2016, instrout_1511};

   task automatic check(input string tag, input logic [146:0] obs, input logic [146:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic apply(input logic [146:0] v);
      {ctlwb_out, ctlm_out, ctlex_out, npc, readdat1, readdat2,
       signext_out, instr_2016, instr_1511} = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [146:0] no_ctl(input logic [146:0] v);
      return {9'b0, v[137:0]};
   endfunction

   initial begin
      vec_a    = {2'd1, 3'd2, 4'd8, 32'h0000AA01, 32'h0011CC00, 32'h00FFFF11,
                  32'hFFFFFF02, 5'd20, 5'd15};
      vec_b    = {2'd3, 3'd4, 4'd5, 32'h0020B000, 32'h0000FF01, 32'h00101234,
                  32'h00000059, 5'd16, 5'd11};
      zero_vec = '0;
      stall = 1'b0;
      flush = 1'b0;
      apply(vec_a);

      // asynchronous reset before any clock edge
      #1 rst_n = 1'b0;
      #1 check("reset_async", got, zero_vec);
      step();
      check("reset_held_edge", got, zero_vec);

      // release between edges; first edge with rst_n=1 loads A
      #3 rst_n = 1'b1;
      step();
      check("load_a", got, vec_a);
      check("load_a_sext", {115'b0, s_extendout}, {115'b0, 32'hFFFFFF02});

      // inputs change between edges: no effect until edge
      apply(vec_b);
      #2 check("b_before_edge", got, vec_a);
      step();
      check("load_b", got, vec_b);

      // stall holds A for two edges while B is presented
      apply(vec_a);
      step();
      check("reload_a", got, vec_a);
      apply(vec_b);
      stall = 1'b1;
      step();
      check("stall_edge1", got, vec_a);
      step();
      check("stall_edge2", got, vec_a);
      stall = 1'b0;
      #2 check("stall_release_pre", got, vec_a);
      step();
      check("stall_release_b", got, vec_b);

      // flush with stall asserted
      apply(vec_a);
      step();
      check("pre_flush_a", got, vec_a);
      apply(vec_b);
      stall = 1'b1;
      flush = 1'b1;
      step();
`ifdef ID_EX_FLUSH_EN
      check("flush_stall", got, no_ctl(vec_b));
`else
      check("flush_stall", got, vec_a);
`endif
      // flush without stall
      stall = 1'b0;
      apply(vec_a);
      step();
`ifdef ID_EX_FLUSH_EN
      check("flush_nostall", got, no_ctl(vec_a));
`else
      check("flush_nostall", got, vec_a);
`endif
      flush = 1'b0;
      apply(vec_b);
      step();
      check("post_flush_b", got, vec_b);

      // mid-run reset between edges discards the pending load
      apply(vec_a);
      #2 rst_n = 1'b0;
      #1 check("midrun_reset", got, zero_vec);
      step();
      check("midrun_reset_edge", got, zero_vec);
      #2 rst_n = 1'b1;
      step();
      check("after_reset_load", got, vec_a);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
